// File: rtl/mips_pkg.sv
// Shared widths, constants and fetch FSM encoding for the MIPS pipeline front end.
package mips_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR            = 16'h0000;
    localparam logic [3:0]         HALT_OPCODE_DEFAULT  = 4'hF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus: fetch unit drives the address, ROM returns the word.
interface instruction_fetch_unit_if;
    import mips_pkg::*;

    logic [ADDR_W-1:0]  imem_address;
    logic [INSTR_W-1:0] imem_instruction;

    modport master (
        output imem_address,
        input  imem_instruction
    );

    modport slave (
        input  imem_address,
        output imem_instruction
    );

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: bubble beats load; hold or no control keeps contents.
module if_id_register
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_bubble,
    input  logic               i_hold,
    input  logic [INSTR_W-1:0] i_instruction,
    input  logic [ADDR_W-1:0]  i_pc_plus2,
    output logic [INSTR_W-1:0] o_instruction,
    output logic [ADDR_W-1:0]  o_pc_plus2,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_instruction;
    logic [ADDR_W-1:0]  r_pc_plus2;
    logic               r_valid;

    // A bubble keeps pc_plus2 so the decode stage never sees a spurious link value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instruction <= NOP_INSTR;
            r_pc_plus2    <= '0;
            r_valid       <= 1'b0;
        end else if (i_bubble) begin
            r_instruction <= NOP_INSTR;
            r_valid       <= 1'b0;
        end else if (i_load && !i_hold) begin
            r_instruction <= i_instruction;
            r_pc_plus2    <= i_pc_plus2;
            r_valid       <= 1'b1;
        end
    end

    assign o_instruction = r_instruction;
    assign o_pc_plus2    = r_pc_plus2;
    assign o_valid       = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, RUN/HALTED FSM, redirect/flush/stall handling and IF/ID capture.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]        HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_target,
    instruction_fetch_unit_if.master  imem,
    output logic [INSTR_W-1:0]        if_id_instruction,
    output logic [ADDR_W-1:0]         if_id_pc_plus2,
    output logic                      if_id_valid,
    output logic                      halted,
    output logic [15:0]               fetch_count
);

    fetch_state_e      r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next, w_pc_plus2;
    logic [15:0]       r_fetch_count;
    logic              w_load, w_bubble, w_hold, w_count;
    logic              w_unused_target_lsb;

    assign w_pc_plus2          = r_pc + 16'd2;
    assign w_unused_target_lsb = redirect_target[0];

    // In HALTED only a redirect moves the PC; flush/stall have nothing left to act on.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        w_hold       = 1'b0;
        w_count      = 1'b0;
        if (redirect_valid) begin
            w_pc_next    = {redirect_target[ADDR_W-1:1], 1'b0};
            w_bubble     = 1'b1;
            w_state_next = RUN;
        end else if (r_state == HALTED) begin
            w_bubble = 1'b1;
        end else if (flush) begin
            w_bubble  = 1'b1;
            w_pc_next = w_pc_plus2;
        end else if (stall) begin
            w_hold = 1'b1;
        end else begin
            w_load  = 1'b1;
            w_count = 1'b1;
            if (imem.imem_instruction[15:12] == HALT_OPCODE) begin
                w_state_next = HALTED;
            end else begin
                w_pc_next = w_pc_plus2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_count && (r_fetch_count != 16'hFFFF)) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end
        end
    end

    if_id_register u_if_id_register (
        .clk           (clk),
        .rst           (rst),
        .i_load        (w_load),
        .i_bubble      (w_bubble),
        .i_hold        (w_hold),
        .i_instruction (imem.imem_instruction),
        .i_pc_plus2    (w_pc_plus2),
        .o_instruction (if_id_instruction),
        .o_pc_plus2    (if_id_pc_plus2),
        .o_valid       (if_id_valid)
    );

    assign imem.imem_address = r_pc;
    assign halted            = (r_state == HALTED);
    assign fetch_count       = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural ROM (word w holds w).
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [15:0] if_id_instruction;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;
    logic        halt_en;

    int checks   = 0;
    int failures = 0;

    instruction_fetch_unit_if u_if ();

    // Word 4 (byte address 8) turns into a HALT when halt_en is set.
    function automatic logic [15:0] rom_word(input logic [15:0] addr, input logic h);
        if (h && addr[15:1] == 15'd4) return 16'hF004;
        return {1'b0, addr[15:1]};
    endfunction

    assign u_if.imem_instruction = rom_word(u_if.imem_address, halt_en);

    instruction_fetch_unit #(
        .RESET_PC    (16'h0000),
        .HALT_OPCODE (4'hF)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .imem              (u_if.master),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus2    (if_id_pc_plus2),
        .if_id_valid       (if_id_valid),
        .halted            (halted),
        .fetch_count       (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [15:0] addr, input logic [15:0] ins,
                              input logic [15:0] pc2, input logic vld, input logic [15:0] cnt);
        check({tag, ".addr"}, {16'h0, u_if.imem_address}, {16'h0, addr});
        check({tag, ".instr"}, {16'h0, if_id_instruction}, {16'h0, ins});
        check({tag, ".pc2"}, {16'h0, if_id_pc_plus2}, {16'h0, pc2});
        check({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, vld});
        check({tag, ".count"}, {16'h0, fetch_count}, {16'h0, cnt});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
        redirect_target = 16'h0; halt_en = 1'b0;
        step(); step();
        check_ifid("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0);
        check("reset.halted", {31'h0, halted}, 32'h0);
        rst = 1'b0;

        // Sequential fetch: 0, 2, then stall at PC=4.
        step();
        check_ifid("fetch0", 16'h0002, 16'h0000, 16'h0002, 1'b1, 16'd1);
        step();
        check_ifid("fetch2", 16'h0004, 16'h0001, 16'h0004, 1'b1, 16'd2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid("stall", 16'h0004, 16'h0001, 16'h0004, 1'b1, 16'd2);
        end
        stall = 1'b0;
        step();
        check_ifid("fetch4", 16'h0006, 16'h0002, 16'h0006, 1'b1, 16'd3);

        // Redirect to an odd target; bit 0 is dropped.
        redirect_valid = 1'b1; redirect_target = 16'h0031;
        step();
        check_ifid("redir.bubble", 16'h0030, 16'h0000, 16'h0006, 1'b0, 16'd3);
        redirect_valid = 1'b0;
        step();
        check_ifid("redir.first", 16'h0032, 16'h0018, 16'h0032, 1'b1, 16'd4);

        // Redirect beats stall.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0010;
        step();
        check_ifid("stall_redir", 16'h0010, 16'h0000, 16'h0032, 1'b0, 16'd4);
        stall = 1'b0; redirect_valid = 1'b0;
        step();
        check_ifid("after_sr", 16'h0012, 16'h0008, 16'h0012, 1'b1, 16'd5);

        // Flush beats stall: bubble and PC still advances.
        flush = 1'b1; stall = 1'b1;
        step();
        check_ifid("flush_stall", 16'h0014, 16'h0000, 16'h0012, 1'b0, 16'd5);
        flush = 1'b0; stall = 1'b0;
        step();
        check_ifid("after_fs", 16'h0016, 16'h000A, 16'h0016, 1'b1, 16'd6);

        // HALT at address 8.
        halt_en = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0008;
        step();
        check_ifid("to_halt", 16'h0008, 16'h0000, 16'h0016, 1'b0, 16'd6);
        redirect_valid = 1'b0;
        step();
        check_ifid("halt_instr", 16'h0008, 16'hF004, 16'h000A, 1'b1, 16'd7);
        check("halt.halted", {31'h0, halted}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            check_ifid("halted", 16'h0008, 16'h0000, 16'h000A, 1'b0, 16'd7);
            check("halted.flag", {31'h0, halted}, 32'h1);
        end
        redirect_valid = 1'b1; redirect_target = 16'h0000;
        step();
        check("unhalt.flag", {31'h0, halted}, 32'h0);
        check("unhalt.addr", {16'h0, u_if.imem_address}, 32'h0);
        redirect_valid = 1'b0; halt_en = 1'b0;
        step();
        check_ifid("restart", 16'h0002, 16'h0000, 16'h0002, 1'b1, 16'd8);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_target = 16'hFFFF;
        step();
        check("wrap.addr", {16'h0, u_if.imem_address}, 32'hFFFE);
        redirect_valid = 1'b0;
        step();
        check_ifid("wrap", 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 16'd9);
        step();
        check_ifid("post_wrap", 16'h0002, 16'h0000, 16'h0002, 1'b1, 16'd10);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        check_ifid("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0);
        check("async_rst.halted", {31'h0, halted}, 32'h0);
        step();
        rst = 1'b0;
        step();
        check_ifid("post_rst", 16'h0002, 16'h0000, 16'h0002, 1'b1, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
